// File: rtl/bit_position_counter_if.sv
// Producer/consumer bundle for bit_position_counter: data word, mode select,
// the soc/eoc conversion handshake, and the shared count bus with per-consumer dav_/rfd.
interface bit_position_counter_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned NCONS = 3
);
  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]     x;
  logic [1:0]       mode;
  logic             soc;
  logic             eoc;
  logic [CW-1:0]    c;
  logic [NCONS-1:0] dav_;
  logic [NCONS-1:0] rfd;

  // Environment side: producer drives data/eoc, consumers drive rfd
  modport master (
    output x, mode, eoc, rfd,
    input  soc, c, dav_
  );

  // Counter side
  modport slave (
    input  x, mode, eoc, rfd,
    output soc, c, dav_
  );
endinterface

// File: rtl/bit_position_counter.sv
// Counts set bits at even, odd or all positions of a captured word and presents the
// count to NCONS consumers. Optional macro BPC_EARLY_EXIT_EN ends the scan once no set bits remain.
module bit_position_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned NCONS = 3
) (
  input  logic                  clock,
  input  logic                  reset_,
  bit_position_counter_if.slave bus
);
  localparam int unsigned CW   = $clog2(W + 1);
  localparam int unsigned HALF = W / 2;

  typedef enum logic [2:0] {
    S0_REQ   = 3'd0,
    S1_WAIT  = 3'd1,
    S2_SCAN  = 3'd2,
    S3_PRES  = 3'd3,
    S4_CLOSE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_sr;
  logic [W-1:0]     w_sr_nxt;
  logic [CW-1:0]    r_acc;
  logic [CW-1:0]    w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_step1;
  logic             w_step1_nxt;
  logic             r_soc;
  logic             w_soc_nxt;
  logic [NCONS-1:0] r_dav_n;
  logic [NCONS-1:0] w_dav_n_nxt;
  logic [CW-1:0]    r_c;
  logic [CW-1:0]    w_c_nxt;

  logic [W-1:0]     w_sr_shift;
  logic             w_last;

  // Step of 1 covers every position; step of 2 keeps only the aligned parity
  assign w_sr_shift = r_step1 ? (r_sr >> 1) : (r_sr >> 2);

`ifdef BPC_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(1)) || (w_sr_shift == '0);
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_state <= S0_REQ;
      r_sr    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_step1 <= 1'b0;
      r_soc   <= 1'b0;
      r_dav_n <= '1;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step1 <= w_step1_nxt;
      r_soc   <= w_soc_nxt;
      r_dav_n <= w_dav_n_nxt;
      r_c     <= w_c_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S0_REQ:   if (!bus.eoc)         w_state_nxt = S1_WAIT;
      S1_WAIT:  if (bus.eoc)          w_state_nxt = S2_SCAN;
      S2_SCAN:  if (w_last)           w_state_nxt = S3_PRES;
      S3_PRES:  if (bus.rfd == '0)    w_state_nxt = S4_CLOSE;
      S4_CLOSE: if (bus.rfd == '1)    w_state_nxt = S0_REQ;
      default:                        w_state_nxt = S0_REQ;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_sr_nxt    = r_sr;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_step1_nxt = r_step1;
    w_soc_nxt   = r_soc;
    w_dav_n_nxt = r_dav_n;
    w_c_nxt     = r_c;
    case (r_state)
      S0_REQ: begin
        w_soc_nxt = 1'b1;
      end
      S1_WAIT: begin
        w_soc_nxt   = 1'b0;
        w_sr_nxt    = (bus.mode == 2'b01) ? (bus.x >> 1) : bus.x;
        w_step1_nxt = bus.mode[1];
        w_cnt_nxt   = bus.mode[1] ? CW'(W) : CW'(HALF);
        w_acc_nxt   = '0;
      end
      S2_SCAN: begin
        w_acc_nxt = r_acc + CW'(r_sr[0]);
        w_sr_nxt  = w_sr_shift;
        w_cnt_nxt = r_cnt - CW'(1);
      end
      S3_PRES: begin
        w_dav_n_nxt = '0;
        w_c_nxt     = r_acc;
      end
      S4_CLOSE: begin
        w_dav_n_nxt = '1;
      end
      default: begin
        w_soc_nxt = 1'b0;
      end
    endcase
  end

  assign bus.soc  = r_soc;
  assign bus.dav_ = r_dav_n;
  assign bus.c    = r_c;
endmodule
